// File: rtl/floor_sched_pkg.sv
// -----------------------------------------------------------------------------
// floor_sched_pkg
// Shared definitions for the elevator floor scheduler:
//   - state_t : scheduler state encoding (also driven out on `estado`)
//   - dir_t   : remembered travel direction for the SCAN policy
//   - default parameter values (floor count, door dwell, move watchdog)
// -----------------------------------------------------------------------------
package floor_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_UP    = 3'd1,
        ST_DOWN  = 3'd2,
        ST_STOP  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam int DEFAULT_FLOORS       = 8;
    localparam int DEFAULT_DWELL        = 16;
    localparam int DEFAULT_MOVE_TIMEOUT = 1024;

endpackage

// File: rtl/floor_scheduler_if.sv
// -----------------------------------------------------------------------------
// floor_scheduler_if
// Bundle of the call / position / command signals between the scheduler and
// its environment (call buttons, position sensing and the motion FSM).
//   master : environment side, drives calls, position, limits, clr_fault
//   slave  : scheduler side, drives commands, door, pending, estado, fault
// Signals:
//   call_req[FLOORS]  per-floor calls          cur_floor[FW]  cab floor index
//   at_floor          cab aligned at floor     top_lim/bott_lim limit flags
//   clr_fault         fault acknowledge        go_up/go_down/halt commands
//   door_open         door dwell active        pending[FLOORS] latched calls
//   estado[3]         state encoding           fault          in FAULT
// -----------------------------------------------------------------------------
interface floor_scheduler_if
    import floor_sched_pkg::*;
#(
    parameter int FLOORS = DEFAULT_FLOORS,
    parameter int FW     = $clog2(FLOORS)
);
    logic [FLOORS-1:0] call_req;
    logic [FW-1:0]     cur_floor;
    logic              at_floor;
    logic              top_lim;
    logic              bott_lim;
    logic              clr_fault;
    logic              go_up;
    logic              go_down;
    logic              halt;
    logic              door_open;
    logic [FLOORS-1:0] pending;
    logic [2:0]        estado;
    logic              fault;

    modport master (
        output call_req, cur_floor, at_floor, top_lim, bott_lim, clr_fault,
        input  go_up, go_down, halt, door_open, pending, estado, fault
    );

    modport slave (
        input  call_req, cur_floor, at_floor, top_lim, bott_lim, clr_fault,
        output go_up, go_down, halt, door_open, pending, estado, fault
    );
endinterface

// File: rtl/floor_req_scan.sv
// -----------------------------------------------------------------------------
// floor_req_scan
// Purely combinational scan of the pending-call vector relative to the cab.
// Ports:
//   pending[FLOORS]     in  latched calls
//   cur_floor[FW]       in  current cab floor
//   at_floor            in  cab aligned with cur_floor
//   above / below       out any pending call strictly above / below cur_floor
//   here                out pending call at cur_floor and cab aligned
//   cur_onehot[FLOORS]  out one-hot of cur_floor (all zero if out of range)
// -----------------------------------------------------------------------------
module floor_req_scan
    import floor_sched_pkg::*;
#(
    parameter int FLOORS = DEFAULT_FLOORS,
    parameter int FW     = $clog2(FLOORS)
) (
    input  logic [FLOORS-1:0] pending,
    input  logic [FW-1:0]     cur_floor,
    input  logic              at_floor,
    output logic              above,
    output logic              below,
    output logic              here,
    output logic [FLOORS-1:0] cur_onehot
);

    logic [FLOORS-1:0] above_vec;
    logic [FLOORS-1:0] below_vec;

    // Per-floor comparison; an out-of-range cur_floor yields an all-zero
    // one-hot, so nothing is ever served at a non-existent floor.
    generate
        for (genvar gi = 0; gi < FLOORS; gi++) begin : g_floor
            assign above_vec[gi]  = pending[gi] & (gi > int'(cur_floor));
            assign below_vec[gi]  = pending[gi] & (gi < int'(cur_floor));
            assign cur_onehot[gi] = (gi == int'(cur_floor));
        end
    endgenerate

    assign above = |above_vec;
    assign below = |below_vec;
    assign here  = at_floor & (|(pending & cur_onehot));

endmodule

// File: rtl/floor_scheduler.sv
// -----------------------------------------------------------------------------
// floor_scheduler
// SCAN (continue-in-direction) request scheduler in front of the elevator
// motion FSM. Latches floor calls, chooses travel direction, drives registered
// go_up / go_down / halt commands, runs the door dwell and traps unsafe
// conditions (limit flags, impossible floor index) into FAULT.
//
// Ports:
//   CLK    in  single clock, rising edge
//   reset  in  asynchronous, active-low
//   bus    floor_scheduler_if.slave (calls, position, limits, commands,
//          door_open, pending, estado, fault)
//
// Optional feature: define FLOOR_SCHED_TIMEOUT_EN to add a movement watchdog.
// While in UP/DOWN a counter clears on every at_floor rising edge; if it runs
// MOVE_TIMEOUT cycles without an arrival the scheduler enters FAULT.
// -----------------------------------------------------------------------------
module floor_scheduler
    import floor_sched_pkg::*;
#(
    parameter int FLOORS       = DEFAULT_FLOORS,
    parameter int FW           = $clog2(FLOORS),
    parameter int DWELL        = DEFAULT_DWELL,
    parameter int MOVE_TIMEOUT = DEFAULT_MOVE_TIMEOUT
) (
    input  logic              CLK,
    input  logic              reset,
    floor_scheduler_if.slave  bus
);

    localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;

    state_t            state_reg, state_next;
    dir_t              last_dir_reg, last_dir_next;
    logic [DCW-1:0]    dwell_cnt_reg, dwell_cnt_next;
    logic [FLOORS-1:0] pending_reg, pending_next;
    logic              go_up_reg, go_down_reg, halt_reg, door_open_reg, fault_reg;

    logic              above, below, here;
    logic [FLOORS-1:0] cur_onehot;
    logic [FLOORS-1:0] served;
    logic              bad_floor;
    logic              stop_call_here;
    logic              timeout_hit;

    floor_req_scan #(
        .FLOORS (FLOORS),
        .FW     (FW)
    ) u_scan (
        .pending    (pending_reg),
        .cur_floor  (bus.cur_floor),
        .at_floor   (bus.at_floor),
        .above      (above),
        .below      (below),
        .here       (here),
        .cur_onehot (cur_onehot)
    );

    // Only reachable when FLOORS is not a power of two.
    assign bad_floor      = (int'(bus.cur_floor) >= FLOORS);
    // A fresh call at the floor we are standing at keeps the door open longer.
    assign stop_call_here = |(bus.call_req & cur_onehot);

`ifdef FLOOR_SCHED_TIMEOUT_EN
    localparam int TW = (MOVE_TIMEOUT > 1) ? $clog2(MOVE_TIMEOUT) : 1;

    logic [TW-1:0] move_cnt_reg, move_cnt_next;
    logic          at_floor_d_reg;

    assign timeout_hit = (move_cnt_reg == TW'(MOVE_TIMEOUT - 1));

    always_comb begin
        move_cnt_next = '0;
        if (state_reg == ST_UP || state_reg == ST_DOWN) begin
            if (bus.at_floor && !at_floor_d_reg) begin
                move_cnt_next = '0;
            end else begin
                move_cnt_next = move_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            move_cnt_reg   <= '0;
            at_floor_d_reg <= 1'b0;
        end else begin
            move_cnt_reg   <= move_cnt_next;
            at_floor_d_reg <= bus.at_floor;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_next     = state_reg;
        last_dir_next  = last_dir_reg;
        dwell_cnt_next = '0;

        case (state_reg)
            ST_IDLE: begin
                if (here) begin
                    state_next = ST_STOP;
                end else if (last_dir_reg == DIR_UP) begin
                    if (above)      state_next = ST_UP;
                    else if (below) state_next = ST_DOWN;
                end else begin
                    if (below)      state_next = ST_DOWN;
                    else if (above) state_next = ST_UP;
                end
            end

            ST_UP: begin
                last_dir_next = DIR_UP;
                // Safety traps outrank a floor stop in the same cycle.
                if (bad_floor || bus.top_lim || timeout_hit) begin
                    state_next = ST_FAULT;
                end else if (here) begin
                    state_next = ST_STOP;
                end else if (bus.at_floor && !above) begin
                    state_next = ST_IDLE;
                end
            end

            ST_DOWN: begin
                last_dir_next = DIR_DOWN;
                if (bad_floor || bus.bott_lim || timeout_hit) begin
                    state_next = ST_FAULT;
                end else if (here) begin
                    state_next = ST_STOP;
                end else if (bus.at_floor && !below) begin
                    state_next = ST_IDLE;
                end
            end

            ST_STOP: begin
                if (stop_call_here) begin
                    dwell_cnt_next = '0;
                end else if (dwell_cnt_reg == DCW'(DWELL - 1)) begin
                    state_next = ST_IDLE;
                end else begin
                    dwell_cnt_next = dwell_cnt_reg + 1'b1;
                end
            end

            ST_FAULT: begin
                if (bus.clr_fault && !bus.top_lim && !bus.bott_lim) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_FAULT;
            end
        endcase
    end

    // Calls at the current floor are consumed on the edge that enters STOP and
    // on every edge while STOP is held.
    always_comb begin
        served = '0;
        if (state_reg == ST_STOP || state_next == ST_STOP) begin
            served = cur_onehot;
        end
        pending_next = (pending_reg | bus.call_req) & ~served;
    end

    // Commands are decoded from the next state so they change on the same
    // edge as the state register.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            last_dir_reg  <= DIR_UP;
            dwell_cnt_reg <= '0;
            pending_reg   <= '0;
            go_up_reg     <= 1'b0;
            go_down_reg   <= 1'b0;
            halt_reg      <= 1'b1;
            door_open_reg <= 1'b0;
            fault_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            last_dir_reg  <= last_dir_next;
            dwell_cnt_reg <= dwell_cnt_next;
            pending_reg   <= pending_next;
            go_up_reg     <= (state_next == ST_UP);
            go_down_reg   <= (state_next == ST_DOWN);
            halt_reg      <= !(state_next == ST_UP || state_next == ST_DOWN);
            door_open_reg <= (state_next == ST_STOP);
            fault_reg     <= (state_next == ST_FAULT);
        end
    end

    assign bus.go_up     = go_up_reg;
    assign bus.go_down   = go_down_reg;
    assign bus.halt      = halt_reg;
    assign bus.door_open = door_open_reg;
    assign bus.pending   = pending_reg;
    assign bus.estado    = state_reg;
    assign bus.fault     = fault_reg;

endmodule
